// File: rtl/display_mux.sv
// Eight-digit time-multiplexed seven-segment driver with a blanking guard between digits.
// Digit 0 latches a coherent snapshot of data/dp_in/blank that digits 1..7 replay.
module display_mux #(
  parameter int GUARD = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_clk,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_sel
);

  typedef enum logic {BLANK, SHOW} state_t;

  localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);

  state_t      state_q;
  logic [3:0]  gcnt_q;
  logic [2:0]  digitSel_q;
  logic        pix_q;
  logic [7:0]  anode_q;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic [31:0] shData_q;
  logic [7:0]  shDp_q;
  logic [7:0]  shBlank_q;

  logic        step;
  logic [3:0]  selNibble;
  logic        selDp;
  logic        selBlank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign step = pix_clk & ~pix_q;

  // Digit 0 takes the live inputs on the same edge they are snapshotted.
  always_comb begin
    selNibble = 4'h0;
    selDp     = 1'b0;
    selBlank  = 1'b0;
    if (digitSel_q == 3'd0) begin
      selNibble = data[3:0];
      selDp     = dp_in[0];
      selBlank  = blank[0];
    end else begin
      selNibble = shData_q[{digitSel_q, 2'b00} +: 4];
      selDp     = shDp_q[digitSel_q];
      selBlank  = shBlank_q[digitSel_q];
    end
  end

  always_ff @(posedge clk_in) begin
    pix_q <= pix_clk;
    if (!reset) begin
      state_q    <= BLANK;
      gcnt_q     <= 4'd0;
      digitSel_q <= 3'd0;
      pix_q      <= 1'b1;
      anode_q    <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      shData_q   <= 32'h0;
      shDp_q     <= 8'h0;
      shBlank_q  <= 8'h0;
    end else begin
      case (state_q)
        SHOW: begin
          if (step) begin
            digitSel_q <= digitSel_q + 3'd1;
            state_q    <= BLANK;
            gcnt_q     <= 4'd0;
            anode_q    <= 8'hFF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
          end
        end
        BLANK: begin
          // A step arriving here is intentionally lost, even on the expiry edge.
          gcnt_q <= gcnt_q + 4'd1;
          if (gcnt_q == GUARD_LAST) begin
            state_q <= SHOW;
            if (digitSel_q == 3'd0) begin
              shData_q  <= data;
              shDp_q    <= dp_in;
              shBlank_q <= blank;
            end
            if (selBlank) begin
              anode_q <= 8'hFF;
              seg_q   <= 7'h7F;
              dp_q    <= 1'b1;
            end else begin
              anode_q <= ~(8'h01 << digitSel_q);
              seg_q   <= decode(selNibble);
              dp_q    <= ~selDp;
            end
          end
        end
        default: state_q <= BLANK;
      endcase
    end
  end

  assign anode     = anode_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = digitSel_q;

endmodule

// File: tb/tb_display_mux.sv
// Directed self-checking bench for display_mux with GUARD = 4.
// Inputs change and outputs are checked on the falling edge of clk_in.
module tb_display_mux;

  logic        clkIn;
  logic        resetN;
  logic        pixClk;
  logic [31:0] dataIn;
  logic [7:0]  dpIn;
  logic [7:0]  blankIn;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  digitSel;

  int checks = 0;
  int errors = 0;

  logic [6:0] segOf [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  display_mux #(.GUARD(4)) dut (
    .clk_in   (clkIn),
    .reset    (resetN),
    .pix_clk  (pixClk),
    .data     (dataIn),
    .dp_in    (dpIn),
    .blank    (blankIn),
    .anode    (anode),
    .seg      (seg),
    .dp       (dp),
    .digit_sel(digitSel)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic applyStimulus(input logic pixVal, input int cycles);
    pixClk = pixVal;
    repeat (cycles) @(negedge clkIn);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expAnode,
                             input logic [6:0] expSeg, input logic expDp,
                             input logic [2:0] expSel);
    checks++;
    assert ({anode, seg, dp, digitSel} === {expAnode, expSeg, expDp, expSel}) else begin
      errors++;
      $error("[TB] FAIL %s: got anode=%h seg=%b dp=%b sel=%0d, expected anode=%h seg=%b dp=%b sel=%0d",
             tag, anode, seg, dp, digitSel, expAnode, expSeg, expDp, expSel);
    end
  endtask

  // One pix_clk rising edge, then exactly four blank cycles before digit k lights.
  task automatic advanceDigit(input logic [2:0] k, input logic [6:0] expSeg,
                              input logic expDp, input logic blanked);
    logic [7:0] expAnode;
    expAnode = blanked ? 8'hFF : ~(8'h01 << k);
    applyStimulus(1'b1, 1);
    checkOutput($sformatf("step_gap%0d", k), 8'hFF, 7'h7F, 1'b1, k);
    applyStimulus(1'b0, 3);
    checkOutput($sformatf("guard%0d", k), 8'hFF, 7'h7F, 1'b1, k);
    applyStimulus(1'b0, 1);
    checkOutput($sformatf("show%0d", k), expAnode, blanked ? 7'h7F : expSeg,
                blanked ? 1'b1 : expDp, k);
  endtask

  initial begin
    resetN  = 1'b0;
    pixClk  = 1'b0;
    dataIn  = 32'h0;
    dpIn    = 8'h0;
    blankIn = 8'h0;
    @(negedge clkIn);

    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    checkOutput("reset", 8'hFF, 7'h7F, 1'b1, 3'd0);

    resetN = 1'b1;
    dataIn = 32'h76543210;
    dpIn   = 8'h01;
    applyStimulus(1'b0, 3);
    checkOutput("release_guard", 8'hFF, 7'h7F, 1'b1, 3'd0);
    applyStimulus(1'b0, 1);
    checkOutput("release_show0", 8'hFE, segOf[0], 1'b0, 3'd0);

    // Frame 1, with data changed mid-frame while digit 3 is lit.
    for (int k = 1; k < 8; k++) begin
      advanceDigit(3'(k), segOf[k], 1'b1, 1'b0);
      if (k == 3) dataIn = 32'hFFFFFFFF;
    end

    for (int k = 0; k < 8; k++)
      advanceDigit(3'(k), segOf[15], (k == 0) ? 1'b0 : 1'b1, 1'b0);

    dataIn  = 32'h76543210;
    blankIn = 8'h80;
    for (int k = 0; k < 8; k++)
      advanceDigit(3'(k), segOf[k], (k == 0) ? 1'b0 : 1'b1, k == 7);
    blankIn = 8'h00;
    advanceDigit(3'd0, segOf[0], 1'b0, 1'b0);

    // pix_clk rises exactly on the guard-expiry edge: the step must be lost.
    applyStimulus(1'b1, 1);
    checkOutput("coinc_gap", 8'hFF, 7'h7F, 1'b1, 3'd1);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 1);
    checkOutput("coinc_show1", 8'hFD, segOf[1], 1'b1, 3'd1);
    applyStimulus(1'b1, 6);
    checkOutput("coinc_hold", 8'hFD, segOf[1], 1'b1, 3'd1);
    applyStimulus(1'b0, 2);
    checkOutput("coinc_low", 8'hFD, segOf[1], 1'b1, 3'd1);

    for (int k = 2; k < 5; k++)
      advanceDigit(3'(k), segOf[k], 1'b1, 1'b0);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 2);
    checkOutput("midblank5", 8'hFF, 7'h7F, 1'b1, 3'd5);
    resetN = 1'b0;
    applyStimulus(1'b0, 1);
    checkOutput("midblank_reset", 8'hFF, 7'h7F, 1'b1, 3'd0);

    // pix_clk goes high under reset and stays high across release.
    applyStimulus(1'b1, 1);
    resetN = 1'b1;
    applyStimulus(1'b1, 3);
    checkOutput("rerelease_guard", 8'hFF, 7'h7F, 1'b1, 3'd0);
    applyStimulus(1'b1, 1);
    checkOutput("rerelease_show0", 8'hFE, segOf[0], 1'b0, 3'd0);
    applyStimulus(1'b1, 1000);
    checkOutput("high_1000", 8'hFE, segOf[0], 1'b0, 3'd0);
    applyStimulus(1'b0, 3);
    checkOutput("low_after_high", 8'hFE, segOf[0], 1'b0, 3'd0);
    advanceDigit(3'd1, segOf[1], 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter GUARD, default 4, number of clk_in cycles all anodes are held off between digits (legal range 1..15).
REQ-002 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk_in.
REQ-004 pix_clk  input  1  square-wave refresh clock from the upstream divider, ~480 Hz, asynchronous in phase to data.
REQ-005 data  input  32  eight hex nibbles; data[4k+3:4k] drives digit k.
REQ-006 dp_in  input  8  decimal point request per digit, active-high.
REQ-007 blank  input  8  per-digit blank request, active-high.
REQ-008 anode  output  8  common-anode enables, active-low, one-hot-low or all-high.
REQ-009 seg  output  7  segments {a,b,c,d,e,f,g} as seg[6:0], active-low.
REQ-010 dp  output  1  decimal point segment, active-low.
REQ-011 digit_sel  output  3  index of current or pending digit.

Function
REQ-012 Register pix_clk into pix_q every cycle; step = pix_clk & ~pix_q; step SHALL fire once per pix_clk rising edge regardless of high-level duration.
REQ-013 FSM states: BLANK, SHOW; 4-bit guard counter gcnt.
REQ-014 SHOW + step: digit_sel <= digit_sel+1, wrapping 7->0; state <= BLANK; gcnt <= 0; anode <= 8'hFF; seg <= 7'h7F; dp <= 1.
REQ-015 SHOW without step: all outputs hold.
REQ-016 BLANK: gcnt increments each cycle; step is ignored; anode = 8'hFF, seg = 7'h7F, dp = 1.
REQ-017 BLANK with gcnt == GUARD-1: state <= SHOW on that edge; a new digit's anode is first driven low on the GUARD-th edge after the step edge.
REQ-018 On BLANK->SHOW with digit_sel == 0: data, dp_in and blank are captured into shadow registers; that same edge uses the live values for digit 0.
REQ-019 Digits 1..7 SHALL use shadow values only; input changes mid-frame do not appear until the next digit 0.
REQ-020 On BLANK->SHOW: if blank[k] (shadow) = 1, anode stays 8'hFF, seg = 7'h7F and dp = 1 for the whole slot. Otherwise anode = ~(8'b1 << k), seg = decode(nibble k) and dp = ~dp_in[k], where k = digit_sel.
REQ-021 Decode, active-low {a..g}:
   - 0=0000001, 1=1001111, 2=0010010, 3=0000110
   - 4=1001100, 5=0100100, 6=0100000, 7=0001111
   - 8=0000000, 9=0000100, A=0001000, b=1100000
   - C=0110001, d=1000010, E=0110000, F=0111000
REQ-022 All outputs SHALL be registered; there is no combinational path from inputs to outputs.
REQ-023 At most one anode bit is low in any cycle.
REQ-024 If step and the GUARD-expiry coincide while in BLANK, expiry wins and step is dropped.

Reset
REQ-025 reset == 0 at a clk_in edge sets the following, overriding all other activity including mid-BLANK and mid-SHOW:
   - anode = 8'hFF, seg = 7'h7F, dp = 1
   - digit_sel = 0, state = BLANK, gcnt = 0
   - shadows = 0
   - pix_q = 1
REQ-026 Because pix_q resets to 1, a pix_clk already high at reset release SHALL NOT produce a step.
REQ-027 After release, digit 0 is shown GUARD edges later with freshly captured shadows; no pix_clk edge is required.

Verification
REQ-028 reset low 3 cycles while pix_clk toggles -> anode FF, seg 7F, dp 1, digit_sel 0; then release with data=32'h76543210, GUARD=4 -> anode FE, seg 0000001 on the 4th edge after release.
REQ-029 data=32'h76543210, dp_in=8'h01, blank=0, 8 pix_clk rising edges:
   - anode sequence FE,FD,FB,F7,EF,DF,BF,7F, each preceded by exactly 4 cycles of FF
   - seg codes for 0..7
   - dp low only in digit 0's slot
REQ-030 While digit 3 is shown, change data to 32'hFFFFFFFF -> digits 4..7 still show 4..7; the next frame shows F on all digits.
REQ-031 blank=8'h80 -> during the digit_sel=7 slot, anode FF and seg 7F; digit_sel reads 7; digit 0 then follows normally.
REQ-032 pix_clk held high across reset release for 1000 cycles, then low, then high -> exactly one step, on that later rising edge.
REQ-033 reset pulled low during BLANK with digit_sel=5 -> next edge gives reset values; after release the sequence restarts at digit 0.
